// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - opcodes and scheduler state encoding shared by the boot flash scheduler
package flash_pkg;

  localparam logic [7:0] OP_READ       = 8'h03;
  localparam logic [7:0] OP_RELEASE_PD = 8'hAB;

  typedef enum logic [2:0] {
    ST_WAKE_CMD,
    ST_WAKE_WAIT,
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_GAP
  } sched_state_t;

endpackage

// File: rtl/spi_shift8.sv
// rtl/spi_shift8.sv - 8-bit SPI mode-0 shifter, 2 clocks per bit, MSB first
// A start in the cycle where last is high chains the next byte with no idle cycle.
module spi_shift8 (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       so,
  output logic       sck,
  output logic       si,
  output logic       active,
  output logic       last,
  output logic [7:0] rx_next
);

  logic       phase_b;
  logic [2:0] bit_cnt;
  logic [6:0] tx_sr;
  logic [6:0] rx_sr;

  assign last    = active && phase_b && (bit_cnt == 3'd0);
  assign rx_next = {rx_sr, so};

  always_ff @(posedge clock) begin
    if (reset) begin
      active  <= 1'b0;
      phase_b <= 1'b0;
      bit_cnt <= 3'd0;
      tx_sr   <= 7'd0;
      rx_sr   <= 7'd0;
      sck     <= 1'b0;
      si      <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      phase_b <= 1'b0;
      bit_cnt <= 3'd7;
      tx_sr   <= tx_data[6:0];
      sck     <= 1'b0;
      si      <= tx_data[7];
    end else if (active) begin
      if (!phase_b) begin
        sck     <= 1'b1;
        phase_b <= 1'b1;
      end else begin
        // so is sampled on the edge that ends the high phase
        rx_sr   <= rx_next[6:0];
        sck     <= 1'b0;
        phase_b <= 1'b0;
        if (bit_cnt == 3'd0) begin
          active <= 1'b0;
          si     <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt - 3'd1;
          tx_sr   <= {tx_sr[5:0], 1'b0};
          si      <= tx_sr[6];
        end
      end
    end
  end

endmodule

// File: rtl/flash_sched.sv
// rtl/flash_sched.sv - boot flash scheduler: power-down release, then prioritized sequential reads
// Owns chip select, byte counters and arbitration; bit timing lives in spi_shift8.
module flash_sched
  import flash_pkg::*;
#(
  parameter int EEPROM_ADDRESS_BITS = 24,
  parameter int LEN_BITS            = 16,
  parameter int WAKE_CYCLES         = 32,
  parameter int CS_HIGH_CYCLES      = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           req0,
  input  logic [EEPROM_ADDRESS_BITS-1:0] req0_addr,
  input  logic [LEN_BITS-1:0]            req0_len,
  input  logic                           req1,
  input  logic [EEPROM_ADDRESS_BITS-1:0] req1_addr,
  input  logic [LEN_BITS-1:0]            req1_len,
  output logic                           gnt0,
  output logic                           gnt1,
  output logic [7:0]                     rd_data,
  output logic                           rd_valid,
  output logic                           rd_id,
  output logic                           done0,
  output logic                           done1,
  output logic                           ready,
  output logic                           busy,
  output logic                           flash_si,
  input  logic                           flash_so,
  output logic                           flash_sck,
  output logic                           flash_cs_n
);

  localparam int          ADDR_BYTES = EEPROM_ADDRESS_BITS / 8;
  localparam logic [15:0] WAKE_LAST  = 16'(WAKE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST   = 16'(CS_HIGH_CYCLES - 1);
  localparam logic [7:0]  ADDR_LAST  = 8'(ADDR_BYTES - 1);

  sched_state_t                   state, state_n;
  logic [EEPROM_ADDRESS_BITS-1:0] addr_q;
  logic [LEN_BITS-1:0]            rem_q;
  logic [7:0]                     addr_left;
  logic [15:0]                    wait_cnt;

  logic       shift_start;
  logic [7:0] shift_tx;
  logic       shift_active;
  logic       shift_last;
  logic [7:0] shift_rx;

  spi_shift8 u_shift (
    .clock   (clock),
    .reset   (reset),
    .start   (shift_start),
    .tx_data (shift_tx),
    .so      (flash_so),
    .sck     (flash_sck),
    .si      (flash_si),
    .active  (shift_active),
    .last    (shift_last),
    .rx_next (shift_rx)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_WAKE_CMD;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    shift_start = 1'b0;
    shift_tx    = 8'h00;
    case (state)
      ST_WAKE_CMD: begin
        if (!shift_active) begin
          shift_start = 1'b1;
          shift_tx    = OP_RELEASE_PD;
        end else if (shift_last) begin
          state_n = ST_WAKE_WAIT;
        end
      end
      ST_WAKE_WAIT: if (wait_cnt == WAKE_LAST) state_n = ST_IDLE;
      ST_IDLE:      if (req0 || req1) state_n = ST_CMD;
      ST_CMD: begin
        if (rem_q == '0) begin
          state_n = ST_GAP;
        end else if (!shift_active) begin
          shift_start = 1'b1;
          shift_tx    = OP_READ;
        end else if (shift_last) begin
          shift_start = 1'b1;
          shift_tx    = addr_q[EEPROM_ADDRESS_BITS-1 -: 8];
          state_n     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (shift_last) begin
          shift_start = 1'b1;
          if (addr_left != 8'd0) shift_tx = addr_q[EEPROM_ADDRESS_BITS-1 -: 8];
          else                   state_n  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (shift_last) begin
          if (rem_q == LEN_BITS'(1)) state_n = ST_GAP;
          else                       shift_start = 1'b1;
        end
      end
      ST_GAP:  if (wait_cnt == GAP_LAST) state_n = ST_IDLE;
      default: state_n = ST_WAKE_CMD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flash_cs_n <= 1'b1;
      ready      <= 1'b0;
      busy       <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= 8'h00;
      rd_id      <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      addr_left  <= 8'd0;
      wait_cnt   <= 16'd0;
    end else begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      rd_valid <= 1'b0;
      wait_cnt <= (state_n != state) ? 16'd0 : wait_cnt + 16'd1;
      if (shift_start) flash_cs_n <= 1'b0;
      case (state)
        ST_WAKE_CMD:  if (shift_last) flash_cs_n <= 1'b1;
        ST_WAKE_WAIT: if (state_n == ST_IDLE) ready <= 1'b1;
        ST_IDLE: begin
          // req0 wins on a tie; the loser simply waits for the next idle cycle
          if (req0 || req1) begin
            busy   <= 1'b1;
            gnt0   <= req0;
            gnt1   <= ~req0;
            rd_id  <= ~req0;
            addr_q <= req0 ? req0_addr : req1_addr;
            rem_q  <= req0 ? req0_len : req1_len;
          end
        end
        ST_CMD: begin
          if (rem_q == '0) begin
            busy  <= 1'b0;
            done0 <= ~rd_id;
            done1 <= rd_id;
          end else if (shift_last) begin
            addr_q    <= addr_q << 8;
            addr_left <= ADDR_LAST;
          end
        end
        ST_ADDR: begin
          if (shift_last && addr_left != 8'd0) begin
            addr_q    <= addr_q << 8;
            addr_left <= addr_left - 8'd1;
          end
        end
        ST_DATA: begin
          if (shift_last) begin
            rd_valid <= 1'b1;
            rd_data  <= shift_rx;
            rem_q    <= rem_q - LEN_BITS'(1);
            if (rem_q == LEN_BITS'(1)) begin
              flash_cs_n <= 1'b1;
              busy       <= 1'b0;
              done0      <= ~rd_id;
              done1      <= rd_id;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
